// File: rtl/led_pattern_monitor.sv
`default_nettype none
// led_pattern_monitor: observes blue/green LED shifter outputs, checks the one-hot
// rotate-left sequence, classifies the step period and keeps sticky error flags.
module led_pattern_monitor #(
  parameter int NB_LEDS   = 4,
  parameter int NB_PERIOD = 8,
  parameter int NB_STEP   = 8,
  parameter int R0_PERIOD = 8,
  parameter int R1_PERIOD = 16,
  parameter int R2_PERIOD = 32,
  parameter int R3_PERIOD = 64,
  parameter int TOL       = 1
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_LEDS-1:0] i_led_b,
  input  logic [NB_LEDS-1:0] i_led_g,
  input  logic               i_clear,
  output logic [1:0]         o_rate,
  output logic               o_rate_valid,
  output logic               o_color,
  output logic               o_err_pattern,
  output logic               o_err_color,
  output logic               o_err_period,
  output logic [NB_STEP-1:0] o_step_count
);

  localparam logic [1:0]           ST_IDLE    = 2'd0;
  localparam logic [1:0]           ST_LOCK    = 2'd1;
  localparam logic [1:0]           ST_TRACK   = 2'd2;
  localparam logic [NB_PERIOD-1:0] PERIOD_MAX = '1;

  logic [1:0]           state;
  logic [1:0]           state_next;

  logic [NB_LEDS-1:0]   samp_b;
  logic [NB_LEDS-1:0]   samp_g;
  logic [NB_LEDS-1:0]   prev_act;
  logic [NB_PERIOD-1:0] period;

  logic [1:0]           rate;
  logic                 rate_valid;
  logic                 color;
  logic                 err_pattern;
  logic                 err_color;
  logic                 err_period;
  logic [NB_STEP-1:0]   step_count;

  logic [NB_LEDS-1:0]   act;
  logic [NB_LEDS-1:0]   act_rotl;
  logic                 act_color;
  logic                 conflict;
  logic                 one_hot;
  logic                 transition;
  logic                 legal;
  logic [3:0]           rate_hit;
  logic                 any_hit;
  logic [1:0]           hit_code;

  logic                 enter_lock;
  logic                 idle_bad;
  logic                 running;
  logic                 step_event;
  logic                 classify;
  logic                 stall;
  logic                 color_change;

  function automatic logic near(input logic [NB_PERIOD-1:0] m, input int nominal);
    int mi;
    mi = int'(m);
    return (mi >= nominal - TOL) && (mi <= nominal + TOL);
  endfunction

  // Sample decode: a cycle with both colours lit carries no event.
  always_comb begin
    conflict  = (samp_b != '0) && (samp_g != '0);
    act       = conflict ? '0 : (samp_b | samp_g);
    act_color = (samp_g != '0);
  end

  assign act_rotl   = {prev_act[NB_LEDS-2:0], prev_act[NB_LEDS-1]};
  assign one_hot    = $onehot(act);
  assign transition = (act != '0) && (act != prev_act);
  assign legal      = one_hot && (act == act_rotl);

  assign rate_hit[0] = near(period, R0_PERIOD);
  assign rate_hit[1] = near(period, R1_PERIOD);
  assign rate_hit[2] = near(period, R2_PERIOD);
  assign rate_hit[3] = near(period, R3_PERIOD);
  assign any_hit     = |rate_hit;
  assign hit_code    = rate_hit[0] ? 2'd0 :
                       rate_hit[1] ? 2'd1 :
                       rate_hit[2] ? 2'd2 : 2'd3;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else if (i_clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (one_hot) state_next = ST_LOCK;
      ST_LOCK:  if (transition && legal) state_next = ST_TRACK;
      ST_TRACK: if (!transition && period == PERIOD_MAX) state_next = ST_LOCK;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    running      = (state == ST_LOCK) || (state == ST_TRACK);
    enter_lock   = (state == ST_IDLE) && one_hot;
    idle_bad     = (state == ST_IDLE) && (act != '0) && !one_hot;
    step_event   = running && transition;
    classify     = (state == ST_TRACK) && transition;
    stall        = (state == ST_TRACK) && !transition && (period == PERIOD_MAX);
    color_change = running && (act != '0) && (act_color != color);
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      samp_b      <= '0;
      samp_g      <= '0;
      prev_act    <= '0;
      period      <= '0;
      rate        <= '0;
      rate_valid  <= 1'b0;
      color       <= 1'b0;
      err_pattern <= 1'b0;
      err_color   <= 1'b0;
      err_period  <= 1'b0;
      step_count  <= '0;
    end else if (i_clear) begin
      samp_b      <= '0;
      samp_g      <= '0;
      prev_act    <= '0;
      period      <= '0;
      rate        <= '0;
      rate_valid  <= 1'b0;
      color       <= 1'b0;
      err_pattern <= 1'b0;
      err_color   <= 1'b0;
      err_period  <= 1'b0;
      step_count  <= '0;
    end else begin
      samp_b <= i_led_b;
      samp_g <= i_led_g;
      // The reference vector survives blank and both-lit cycles.
      if (act != '0) prev_act <= act;
      if (conflict)  err_color <= 1'b1;
      if (idle_bad)  err_pattern <= 1'b1;
      if (enter_lock) begin
        color  <= act_color;
        period <= {{(NB_PERIOD-1){1'b0}}, 1'b1};
      end
      if (color_change) begin
        err_color <= 1'b1;
        color     <= act_color;
      end
      if (step_event) begin
        period <= {{(NB_PERIOD-1){1'b0}}, 1'b1};
        if (legal) step_count <= step_count + 1'b1;
        else       err_pattern <= 1'b1;
      end else if (running && period != PERIOD_MAX) begin
        period <= period + 1'b1;
      end
      if (classify) begin
        if (any_hit) begin
          rate       <= hit_code;
          rate_valid <= 1'b1;
        end else begin
          err_period <= 1'b1;
          rate_valid <= 1'b0;
        end
      end
      if (stall) rate_valid <= 1'b0;
    end
  end

  assign o_rate        = rate;
  assign o_rate_valid  = rate_valid;
  assign o_color       = color;
  assign o_err_pattern = err_pattern;
  assign o_err_color   = err_color;
  assign o_err_period  = err_period;
  assign o_step_count  = step_count;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_monitor.sv
`default_nettype none
// tb_led_pattern_monitor: directed + random stimulus against an in-bench reference
// model of the LED monitor, checked on every falling clock edge.
module tb_led_pattern_monitor;

  logic       clock = 1'b0;
  logic       i_reset = 1'b1;
  logic [3:0] i_led_b = '0;
  logic [3:0] i_led_g = '0;
  logic       i_clear = 1'b0;
  logic [1:0] o_rate;
  logic       o_rate_valid;
  logic       o_color;
  logic       o_err_pattern;
  logic       o_err_color;
  logic       o_err_period;
  logic [7:0] o_step_count;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 0;

  // reference model
  int ms_b, ms_g, m_last, m_elapsed;
  bit m_locked, m_timing;
  int e_rate, e_valid, e_color, e_err_pattern, e_err_color, e_err_period, e_steps;
  int nominal[4] = '{8, 16, 32, 64};

  always #5 clock = ~clock;

  led_pattern_monitor dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_led_b      (i_led_b),
    .i_led_g      (i_led_g),
    .i_clear      (i_clear),
    .o_rate       (o_rate),
    .o_rate_valid (o_rate_valid),
    .o_color      (o_color),
    .o_err_pattern(o_err_pattern),
    .o_err_color  (o_err_color),
    .o_err_period (o_err_period),
    .o_step_count (o_step_count)
  );

  task automatic check(string name, int actual, int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int next_pos(int v);
    return (v == 8) ? 1 : v * 2;
  endfunction

  task automatic model_reset();
    ms_b = 0; ms_g = 0; m_last = 0; m_elapsed = 0;
    m_locked = 0; m_timing = 0;
    e_rate = 0; e_valid = 0; e_color = 0;
    e_err_pattern = 0; e_err_color = 0; e_err_period = 0; e_steps = 0;
  endtask

  task automatic model_classify(int m);
    for (int n = 0; n < 4; n++) begin
      if (m - nominal[n] <= 1 && nominal[n] - m <= 1) begin
        e_rate = n; e_valid = 1; return;
      end
    end
    e_err_period = 1; e_valid = 0;
  endtask

  // Called at every rising edge with the inputs the DUT is sampling there.
  task automatic model_step();
    int a, col;
    bit both, hot, trans, legal;
    if (!i_reset || i_clear) begin model_reset(); return; end
    both  = (ms_b != 0) && (ms_g != 0);
    a     = both ? 0 : (ms_b | ms_g);
    col   = (ms_g != 0) ? 1 : 0;
    hot   = (a != 0) && ($countones(a) == 1);
    trans = (a != 0) && (a != m_last);
    legal = hot && (m_last != 0) && (a == next_pos(m_last));
    if (both) e_err_color = 1;
    if (!m_locked) begin
      if (hot) begin
        m_locked = 1; m_timing = 0; e_color = col; m_elapsed = 1;
      end else if (a != 0) begin
        e_err_pattern = 1;
      end
    end else begin
      if (a != 0 && col != e_color) begin e_err_color = 1; e_color = col; end
      if (trans) begin
        if (m_timing) model_classify(m_elapsed > 255 ? 255 : m_elapsed);
        if (legal) begin e_steps = (e_steps + 1) % 256; m_timing = 1; end
        else e_err_pattern = 1;
        m_elapsed = 1;
      end else begin
        if (m_timing && m_elapsed >= 255) begin e_valid = 0; m_timing = 0; end
        m_elapsed++;
      end
    end
    if (a != 0) m_last = a;
    ms_b = int'(i_led_b);
    ms_g = int'(i_led_g);
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      check("rate",        int'(o_rate),        e_valid ? e_rate : int'(o_rate) == e_rate ? e_rate : e_rate);
      check("rate_valid",  int'(o_rate_valid),  e_valid);
      check("color",       int'(o_color),       e_color);
      check("err_pattern", int'(o_err_pattern), e_err_pattern);
      check("err_color",   int'(o_err_color),   e_err_color);
      check("err_period",  int'(o_err_period),  e_err_period);
      check("step_count",  int'(o_step_count),  e_steps);
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic hold(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(int b, int g);
    i_led_b = b[3:0];
    i_led_g = g[3:0];
  endtask

  task automatic clear_pulse();
    drive(0, 0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic blue_seq(int first, int count, int gap);
    int v;
    v = first;
    for (int i = 0; i < count; i++) begin
      drive(v, 0); hold(gap); v = next_pos(v);
    end
  endtask

  task automatic green_seq(int first, int count, int gap);
    int v;
    v = first;
    for (int i = 0; i < count; i++) begin
      drive(0, v); hold(gap); v = next_pos(v);
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rate"},  int'(o_rate), 0);
    check({tag, "_valid"}, int'(o_rate_valid), 0);
    check({tag, "_color"}, int'(o_color), 0);
    check({tag, "_errs"},  int'({o_err_pattern, o_err_color, o_err_period}), 0);
    check({tag, "_steps"}, int'(o_step_count), 0);
  endtask

  int gaps[16] = '{3, 7, 8, 9, 15, 16, 17, 20, 31, 32, 33, 40, 63, 64, 65, 5};

  initial begin
    int vec, col, r, gap;
    #2 i_reset = 1'b0;
    model_reset();
    cmp_en = 1;
    hold(3);
    check_all_zero("reset");
    i_reset = 1'b1;
    hold(2);

    // Blue rotation at 16 clocks per step
    blue_seq(1, 6, 16);
    check("s1_rate", int'(o_rate), 1);
    check("s1_valid", int'(o_rate_valid), 1);
    check("s1_color", int'(o_color), 0);
    check("s1_steps", int'(o_step_count), 5);
    check("s1_errs", int'({o_err_pattern, o_err_color, o_err_period}), 0);

    // Green: 8-clock steps, then a 64-clock step
    clear_pulse();
    green_seq(1, 4, 8);
    check("s2_rate0", int'(o_rate), 0);
    check("s2_color", int'(o_color), 1);
    green_seq(1, 2, 64);
    check("s2_rate3", int'(o_rate), 3);
    check("s2_errs", int'({o_err_pattern, o_err_color, o_err_period}), 0);

    // Non-one-hot vector while tracking, then clear
    clear_pulse();
    blue_seq(1, 3, 16);
    drive(3, 0); hold(2);
    check("s3_errpat", int'(o_err_pattern), 1);
    hold(10);
    check("s3_sticky", int'(o_err_pattern), 1);
    clear_pulse();
    check_all_zero("s3_clear");
    hold(3);

    // Colour conflict, then green takes over
    blue_seq(1, 3, 16);
    drive(4, 4); hold(4);
    check("s4_conflict", int'(o_err_color), 1);
    green_seq(8, 3, 16);
    check("s4_color", int'(o_color), 1);
    check("s4_errcol", int'(o_err_color), 1);

    // Stall, resume, off-rate step
    clear_pulse();
    blue_seq(1, 3, 16);
    drive(8, 0); hold(300);
    check("s5_stall_valid", int'(o_rate_valid), 0);
    check("s5_stall_noerr", int'(o_err_period), 0);
    blue_seq(1, 2, 16);
    check("s5_resume_rate", int'(o_rate), 1);
    check("s5_resume_valid", int'(o_rate_valid), 1);
    blue_seq(4, 1, 20);
    drive(8, 0); hold(4);
    check("s5_errperiod", int'(o_err_period), 1);
    check("s5_invalid", int'(o_rate_valid), 0);

    // Asynchronous reset between edges while tracking
    clear_pulse();
    blue_seq(1, 4, 16);
    #2 i_reset = 1'b0;
    model_reset();
    #1 check_all_zero("s6_async");
    tick(); tick();
    i_reset = 1'b1;
    hold(2);
    blue_seq(4, 2, 16);
    check("s6_relock_steps", int'(o_step_count), 1);
    check("s6_relock_color", int'(o_color), 0);

    // Randomized traffic
    clear_pulse();
    vec = 1; col = 0;
    for (int seg = 0; seg < 200; seg++) begin
      r = $urandom_range(0, 31);
      gap = gaps[$urandom_range(0, 15)];
      if (r == 0) begin
        clear_pulse();
      end else if (r == 1) begin
        if (col == 1) drive(0, vec | next_pos(vec)); else drive(vec | next_pos(vec), 0);
        hold($urandom_range(2, 10));
      end else if (r == 2) begin
        drive(vec, vec); hold($urandom_range(1, 3));
      end else if (r == 3) begin
        col = 1 - col; vec = next_pos(vec);
      end else if (r == 4) begin
        vec = 1 << $urandom_range(0, 3);
      end else if (r == 5) begin
        drive(0, 0); hold($urandom_range(1, 4));
      end else if (r == 6) begin
        gap = $urandom_range(250, 300);
        vec = next_pos(vec);
      end else begin
        vec = next_pos(vec);
      end
      if (col == 1) drive(0, vec); else drive(vec, 0);
      hold(gap);
    end

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
